onfi_cmd_seq: RTL

- Sequences one ONFI command transaction on the NAND pins: command latch, 0-5 address cycles, optional tWB + R/B# wait, optional N-byte data read.
- Sits between the wishbone register block (command word, address, start) and the NAND pads.
- Asynchronous-mode bus timing uses programmable cycle counts.
- Read bytes stream out on a valid strobe for capture by a later buffer.

---
 rtl/onfi_cmd_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/onfi_cmd_seq.sv
// onfi_cmd_seq: sequences one ONFI command/address/wait/read transaction on the NAND pins
module onfi_cmd_seq #(
   parameter int T_WP       = 2,
   parameter int T_WH       = 2,
   parameter int T_RP       = 2,
   parameter int T_REH      = 2,
   parameter int T_WB       = 4,
   parameter int RB_TIMEOUT = 1024,
   parameter int CNT_W      = 16
) (
   input  logic        mm_clk_i,
   input  logic        mm_rst_n_i,
   input  logic        start_i,
   input  logic [31:0] cmd_i,
   input  logic [39:0] addr_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [7:0]  rd_data_o,
   output logic        rd_valid_o,
   output logic        nand_ce_n_o,
   output logic        nand_cle_o,
   output logic        nand_ale_o,
   output logic        nand_we_n_o,
   output logic        nand_re_n_o,
   output logic [7:0]  nand_dq_o,
   output logic        nand_dq_oe_o,
   input  logic [7:0]  nand_dq_i,
   input  logic        nand_rb_n_i
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_ADDR    = 3'd2;
   localparam logic [2:0] S_WB      = 3'd3;
   localparam logic [2:0] S_WAIT_RB = 3'd4;
   localparam logic [2:0] S_READ    = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;
   localparam logic [CNT_W-1:0] C_WP      = CNT_W'(T_WP);
   localparam logic [CNT_W-1:0] C_LAT_END = CNT_W'(T_WP + T_WH - 1);
   localparam logic [CNT_W-1:0] C_RP      = CNT_W'(T_RP);
   localparam logic [CNT_W-1:0] C_RP_LAST = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] C_RD_END  = CNT_W'(T_RP + T_REH - 1);
   localparam logic [CNT_W-1:0] C_WB_END  = CNT_W'(T_WB - 1);
   localparam logic [CNT_W-1:0] C_TO_END  = CNT_W'(RB_TIMEOUT - 1);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_opcode;
   logic [2:0]       r_naddr;
   logic             r_wait_rb;
   logic             r_rd_en;
   logic [7:0]       r_left;
   logic [39:0]      r_addr;
   logic [2:0]       r_idx;
   logic             r_err;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;
   logic             r_rb_meta;
   logic             r_rb_s;
   logic             w_lat_end;
   logic             w_latch;
   logic [2:0]       w_after_lat;
   logic [39:0]      w_addr_sh;
   logic             w_unused_cmd;

   assign w_lat_end    = r_cnt == C_LAT_END;
   assign w_after_lat  = r_wait_rb ? S_WB : r_rd_en ? S_READ : S_DONE;
   assign w_addr_sh    = r_addr >> {r_idx, 3'b000};
   assign w_latch      = nand_cle_o | nand_ale_o;
   assign w_unused_cmd = ^{cmd_i[31:24], cmd_i[15:13]};

   assign busy_o       = r_state != S_IDLE;
   assign done_o       = r_state == S_DONE;
   assign err_o        = r_err;
   assign rd_data_o    = r_rd_data;
   assign rd_valid_o   = r_rd_valid;
   assign nand_ce_n_o  = r_state == S_IDLE || r_state == S_DONE;
   assign nand_cle_o   = r_state == S_CMD;
   assign nand_ale_o   = r_state == S_ADDR;
   assign nand_dq_oe_o = w_latch;
   assign nand_we_n_o  = !(w_latch && r_cnt < C_WP);
   assign nand_re_n_o  = !(r_state == S_READ && r_cnt < C_RP);
   assign nand_dq_o    = nand_cle_o ? r_opcode : nand_ale_o ? w_addr_sh[7:0] : 8'h00;

   // bring the asynchronous R/B# into the clock domain
   always_ff @(posedge mm_clk_i or negedge mm_rst_n_i) begin
      if (!mm_rst_n_i) begin
         r_rb_meta <= 1'b0;
         r_rb_s    <= 1'b0;
      end else begin
         r_rb_meta <= nand_rb_n_i;
         r_rb_s    <= r_rb_meta;
      end
   end

   // transaction FSM with per-phase cycle counter and read capture
   always_ff @(posedge mm_clk_i or negedge mm_rst_n_i) begin
      if (!mm_rst_n_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_opcode   <= 8'h00;
         r_naddr    <= 3'd0;
         r_wait_rb  <= 1'b0;
         r_rd_en    <= 1'b0;
         r_left     <= 8'h00;
         r_addr     <= 40'h0;
         r_idx      <= 3'd0;
         r_err      <= 1'b0;
         r_rd_data  <= 8'h00;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_cnt      <= r_cnt + CNT_W'(1);
         case (r_state)
            S_IDLE: if (start_i) begin
               r_opcode  <= cmd_i[7:0];
               r_naddr   <= cmd_i[10:8] > 3'd5 ? 3'd5 : cmd_i[10:8];
               r_wait_rb <= cmd_i[11];
               r_rd_en   <= cmd_i[12];
               r_left    <= cmd_i[23:16];
               r_addr    <= addr_i;
               r_idx     <= 3'd0;
               r_err     <= 1'b0;
               r_cnt     <= '0;
               r_state   <= S_CMD;
            end
            S_CMD: if (w_lat_end) begin
               r_cnt   <= '0;
               r_state <= r_naddr != 3'd0 ? S_ADDR : w_after_lat;
            end
            S_ADDR: if (w_lat_end) begin
               r_cnt <= '0;
               r_idx <= r_idx + 3'd1;
               if (r_idx == r_naddr - 3'd1) r_state <= w_after_lat;
            end
            S_WB: if (r_cnt == C_WB_END) begin
               r_cnt   <= '0;
               r_state <= S_WAIT_RB;
            end
            S_WAIT_RB: if (r_rb_s) begin
               r_cnt   <= '0;
               r_state <= r_rd_en ? S_READ : S_DONE;
            end else if (r_cnt == C_TO_END) begin
               r_cnt   <= '0;
               r_err   <= 1'b1;
               r_state <= S_DONE;
            end
            S_READ: begin
               if (r_cnt == C_RP_LAST) begin
                  r_rd_data  <= nand_dq_i;
                  r_rd_valid <= 1'b1;
               end
               if (r_cnt == C_RD_END) begin
                  r_cnt  <= '0;
                  r_left <= r_left - 8'd1;
                  if (r_left == 8'd0) r_state <= S_DONE;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
